dpi_flow_ctx_sequencer: RTL and testbench

//  Upstream feeder for one regex DFA engine (char_in/state_in/state_out/accept_out interface).

---
 rtl/dpi_ctx_defs_pkg.sv | 25 ++
 rtl/dpi_ctx_ram.sv | 56 +++++
 rtl/dpi_flow_ctx_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_dpi_flow_ctx_sequencer.sv | 489 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpi_ctx_defs_pkg.sv
// Shared definitions for the DPI flow-context sequencer.
//   - Default FLOW_W / STATE_W / OFF_W parameter values and statistics width.
//   - Sequencer FSM state type.
//   - Saturating increment used by the optional statistics counters.
package dpi_ctx_defs_pkg;

  localparam int unsigned FLOW_W_DEF  = 4;
  localparam int unsigned STATE_W_DEF = 11;
  localparam int unsigned OFF_W_DEF   = 16;
  localparam int unsigned STAT_W      = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RESTORE = 3'd2,
    ST_STREAM  = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_SAVE    = 3'd5
  } seq_state_t;

  function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/dpi_ctx_ram.sv
// Per-flow DFA context store: 2**AW entries of DW bits plus a valid bitmap.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset (clears valid bitmap)
//   rd_en, rd_addr, rd_data  registered read; an invalid entry reads as 0
//   wr_en, wr_addr, wr_data  write; sets the entry's valid bit
//   clr_en, clr_addr         invalidate one entry; wins over a same-cycle write
module dpi_ctx_ram #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic             rd_hit;

  // Storage itself needs no reset: every read is qualified by the valid bitmap.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else begin
      if (wr_en)  valid[wr_addr]  <= 1'b1;
      if (clr_en) valid[clr_addr] <= 1'b0;
    end
  end

  // A clear landing in the read cycle must already hide the entry.
  always_comb begin
    rd_hit = valid[rd_addr] && !(clr_en && (clr_addr == rd_addr));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_hit ? mem[rd_addr] : '0;
    end
  end

endmodule

// File: rtl/dpi_flow_ctx_sequencer.sv
// Upstream feeder for one regex DFA engine. Restores a flow's saved DFA state
// at SOP, streams payload bytes into the engine, saves the engine state at EOP,
// and reports accepts as (flow, in-packet byte offset) events.
// Optional feature macro: DPI_FLOW_STATS_EN (builds stat_* counters; otherwise 0).
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   pkt_byte/vld/sop/eop/flow        packet byte stream in; pkt_flow sampled on SOP
//   pkt_rdy                          byte accepted when pkt_vld & pkt_rdy
//   eng_char, eng_char_vld           byte to engine
//   eng_state, eng_state_vld         restored state to engine
//   eng_state_cur, eng_accept        engine current state / accept
//   ctx_clr, ctx_clr_flow            invalidate one context entry
//   match_vld/flow/off               one-cycle match event
//   busy                             FSM not idle
//   stat_pkts/stat_matches/stat_errs saturating statistics
module dpi_flow_ctx_sequencer
  import dpi_ctx_defs_pkg::*;
#(
  parameter int unsigned FLOW_W  = FLOW_W_DEF,
  parameter int unsigned STATE_W = STATE_W_DEF,
  parameter int unsigned OFF_W   = OFF_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         pkt_byte,
  input  logic               pkt_vld,
  input  logic               pkt_sop,
  input  logic               pkt_eop,
  input  logic [FLOW_W-1:0]  pkt_flow,
  output logic               pkt_rdy,
  output logic [7:0]         eng_char,
  output logic               eng_char_vld,
  output logic [STATE_W-1:0] eng_state,
  output logic               eng_state_vld,
  input  logic [STATE_W-1:0] eng_state_cur,
  input  logic               eng_accept,
  input  logic               ctx_clr,
  input  logic [FLOW_W-1:0]  ctx_clr_flow,
  output logic               match_vld,
  output logic [FLOW_W-1:0]  match_flow,
  output logic [OFF_W-1:0]   match_off,
  output logic               busy,
  output logic [STAT_W-1:0]  stat_pkts,
  output logic [STAT_W-1:0]  stat_matches,
  output logic [STAT_W-1:0]  stat_errs
);

  seq_state_t         state, state_nxt;
  logic [FLOW_W-1:0]  flow_q;
  logic [OFF_W-1:0]   off_cnt;
  logic [OFF_W-1:0]   char_off;
  logic [STATE_W-1:0] ctx_rd_data;
  logic               ctx_rd, ctx_wr;
  logic               accept;
  logic               sop_late;

  // A SOP arriving after the packet's first byte means the previous EOP went missing.
  always_comb begin
    sop_late = pkt_sop && (off_cnt != '0);
  end

  always_comb begin
    state_nxt     = state;
    pkt_rdy       = 1'b0;
    ctx_rd        = 1'b0;
    ctx_wr        = 1'b0;
    eng_state_vld = 1'b0;
    eng_state     = '0;
    unique case (state)
      ST_IDLE: begin
        // Orphan non-SOP bytes are swallowed; a SOP byte is held for STREAM.
        pkt_rdy = pkt_vld && !pkt_sop;
        if (pkt_vld && pkt_sop) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        ctx_rd    = 1'b1;
        state_nxt = ST_RESTORE;
      end
      ST_RESTORE: begin
        eng_state_vld = 1'b1;
        eng_state     = ctx_rd_data;
        state_nxt     = ST_STREAM;
      end
      ST_STREAM: begin
        pkt_rdy = !sop_late;
        if (pkt_vld && (sop_late || pkt_eop)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        state_nxt = ST_SAVE;
      end
      ST_SAVE: begin
        ctx_wr    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    accept = (state == ST_STREAM) && pkt_vld && pkt_rdy;
    busy   = (state != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flow_q <= '0;
    end else if ((state == ST_IDLE) && pkt_vld && pkt_sop) begin
      flow_q <= pkt_flow;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_cnt <= '0;
    end else if (state == ST_RESTORE) begin
      off_cnt <= '0;
    end else if (accept && (off_cnt != '1)) begin
      off_cnt <= off_cnt + OFF_W'(1);
    end
  end

  // Byte pipeline stage: the accepted byte and its offset travel together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_char_vld <= 1'b0;
      eng_char     <= '0;
      char_off     <= '0;
    end else begin
      eng_char_vld <= accept;
      if (accept) begin
        eng_char <= pkt_byte;
        char_off <= off_cnt;
      end
    end
  end

  // flow_q is still the streaming flow here: the last byte's accept lands in SAVE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_vld  <= 1'b0;
      match_flow <= '0;
      match_off  <= '0;
    end else begin
      match_vld <= eng_char_vld && eng_accept;
      if (eng_char_vld && eng_accept) begin
        match_flow <= flow_q;
        match_off  <= char_off;
      end
    end
  end

  dpi_ctx_ram #(
    .AW (FLOW_W),
    .DW (STATE_W)
  ) u_ctx_ram (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (ctx_rd),
    .rd_addr  (flow_q),
    .rd_data  (ctx_rd_data),
    .wr_en    (ctx_wr),
    .wr_addr  (flow_q),
    .wr_data  (eng_state_cur),
    .clr_en   (ctx_clr),
    .clr_addr (ctx_clr_flow)
  );

`ifdef DPI_FLOW_STATS_EN
  logic              err_evt;
  logic [STAT_W-1:0] pkts_q, matches_q, errs_q;

  assign err_evt = ((state == ST_IDLE) && pkt_vld && !pkt_sop) ||
                   ((state == ST_STREAM) && pkt_vld && sop_late);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkts_q    <= '0;
      matches_q <= '0;
      errs_q    <= '0;
    end else begin
      if (state == ST_SAVE) pkts_q    <= stat_inc(pkts_q);
      if (match_vld)        matches_q <= stat_inc(matches_q);
      if (err_evt)          errs_q    <= stat_inc(errs_q);
    end
  end

  assign stat_pkts    = pkts_q;
  assign stat_matches = matches_q;
  assign stat_errs    = errs_q;
`else
  assign stat_pkts    = '0;
  assign stat_matches = '0;
  assign stat_errs    = '0;
`endif

endmodule

// File: tb/tb_dpi_flow_ctx_sequencer.sv
// Bench for dpi_flow_ctx_sequencer with a small DFA engine matching "yep yep".
// The reference model keeps per-flow byte history and expects a match
// wherever that history ends in "yep yep".
module tb_dpi_flow_ctx_sequencer;

`ifdef DPI_FLOW_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  pkt_byte = '0;
  logic        pkt_vld = 1'b0, pkt_sop = 1'b0, pkt_eop = 1'b0;
  logic [3:0]  pkt_flow = '0;
  logic        pkt_rdy;
  logic [7:0]  eng_char;
  logic        eng_char_vld;
  logic [10:0] eng_state;
  logic        eng_state_vld;
  logic [10:0] eng_state_cur;
  logic        eng_accept;
  logic        ctx_clr = 1'b0;
  logic [3:0]  ctx_clr_flow = '0;
  logic        match_vld;
  logic [3:0]  match_flow;
  logic [15:0] match_off;
  logic        busy;
  logic [31:0] stat_pkts, stat_matches, stat_errs;

  dpi_flow_ctx_sequencer #(.FLOW_W(4), .STATE_W(11), .OFF_W(16)) dut (
    .clk(clk), .rst(rst),
    .pkt_byte(pkt_byte), .pkt_vld(pkt_vld), .pkt_sop(pkt_sop), .pkt_eop(pkt_eop),
    .pkt_flow(pkt_flow), .pkt_rdy(pkt_rdy),
    .eng_char(eng_char), .eng_char_vld(eng_char_vld),
    .eng_state(eng_state), .eng_state_vld(eng_state_vld),
    .eng_state_cur(eng_state_cur), .eng_accept(eng_accept),
    .ctx_clr(ctx_clr), .ctx_clr_flow(ctx_clr_flow),
    .match_vld(match_vld), .match_flow(match_flow), .match_off(match_off),
    .busy(busy), .stat_pkts(stat_pkts), .stat_matches(stat_matches), .stat_errs(stat_errs)
  );

  always #5 clk = ~clk;

  // ---------------- DFA engine for "yep yep" ----------------
  function automatic int dfa_next(input int s, input byte c);
    string pat;
    byte   t [8];
    int    len;
    bit    ok;
    pat = "yep yep";
    for (int i = 0; i < s; i++) t[i] = pat[i];
    t[s] = c;
    len  = s + 1;
    for (int k = (len > 7) ? 7 : len; k > 0; k--) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++) if (t[len - k + j] != pat[j]) ok = 1'b0;
      if (ok) return k;
    end
    return 0;
  endfunction

  logic [10:0] dfa_q = '0;
  always @(posedge clk) begin
    if (eng_state_vld)     dfa_q <= eng_state;
    else if (eng_char_vld) dfa_q <= 11'(dfa_next(int'(dfa_q), eng_char));
  end
  assign eng_state_cur = dfa_q;
  assign eng_accept    = eng_char_vld && (dfa_next(int'(dfa_q), eng_char) == 7);

  // ---------------- reference model ----------------
  typedef struct packed { logic [3:0] flow; logic [15:0] off; } mev_t;
  typedef byte bq_t[$];

  byte  hist [16][$];
  mev_t exp_q[$];
  mev_t got_q[$];
  int   m_pkts, m_errs, m_matches;
  int   n_tests = 0, n_fail = 0;
  int   n_char_vld = 0, n_overlap = 0;
  logic [10:0] last_restore = '0;

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic void model_clear_all();
    for (int f = 0; f < 16; f++) hist[f].delete();
    exp_q.delete();
    got_q.delete();
    m_pkts = 0; m_errs = 0; m_matches = 0;
  endfunction

  function automatic void model_byte(input int f, input byte c, input int off);
    string pat;
    bit    hit;
    mev_t  e;
    pat = "yep yep";
    hist[f].push_back(c);
    if (hist[f].size() > 7) void'(hist[f].pop_front());
    hit = (hist[f].size() == 7);
    for (int j = 0; j < 7; j++) if (hit && hist[f][j] != pat[j]) hit = 1'b0;
    if (hit) begin
      e.flow = f[3:0];
      e.off  = (off > 65535) ? 16'hFFFF : off[15:0];
      exp_q.push_back(e);
      m_matches++;
    end
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (match_vld) got_q.push_back(mev_t'{match_flow, match_off});
    if (eng_state_vld) last_restore = eng_state;
    if (eng_char_vld) n_char_vld++;
    if (eng_char_vld && eng_state_vld) n_overlap++;
  end

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    pkt_vld = 1'b0; pkt_sop = 1'b0; pkt_eop = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    ctx_clr = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_clear_all();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin @(negedge clk); n++; end
    if (busy) begin
      n_tests++; n_fail++;
      $display("FAIL wait_idle: busy=%0b required 0 after %0d cycles", busy, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic settle();
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input int f, input bq_t data, input bit with_eop);
    for (int i = 0; i < data.size(); i++) begin
      int budget;
      bit acc;
      pkt_vld = 1'b1; pkt_byte = data[i]; pkt_flow = f[3:0];
      pkt_sop = (i == 0);
      pkt_eop = with_eop && (i == data.size() - 1);
      acc = 1'b0; budget = 0;
      while (!acc && budget < 50) begin
        @(negedge clk); acc = pkt_rdy;
        @(posedge clk); #1; budget++;
      end
      if (!acc) begin
        n_tests++; n_fail++;
        $display("FAIL send_pkt: flow %0d byte %0d pkt_rdy=0 required 1 within 50 cycles", f, i);
      end else begin
        model_byte(f, data[i], i);
      end
    end
    idle_inputs();
    m_pkts++;
    if (!with_eop) m_errs++;
  endtask

  task automatic send_orphans(input bq_t data);
    for (int i = 0; i < data.size(); i++) begin
      int budget;
      bit acc;
      pkt_vld = 1'b1; pkt_byte = data[i]; pkt_sop = 1'b0; pkt_eop = 1'b0;
      acc = 1'b0; budget = 0;
      while (!acc && budget < 50) begin
        @(negedge clk); acc = pkt_rdy;
        @(posedge clk); #1; budget++;
      end
      if (!acc) begin
        n_tests++; n_fail++;
        $display("FAIL send_orphans: byte %0d pkt_rdy=0 required 1 within 50 cycles", i);
      end
      m_errs++;
    end
    idle_inputs();
  endtask

  task automatic pulse_clr(input int f);
    ctx_clr = 1'b1; ctx_clr_flow = f[3:0];
    @(posedge clk); #1;
    ctx_clr = 1'b0;
    hist[f].delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    n_tests++;
    if ({busy, pkt_rdy, eng_char_vld, eng_state_vld, match_vld} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy/rdy/char_vld/state_vld/match_vld=%b required 00000",
               {busy, pkt_rdy, eng_char_vld, eng_state_vld, match_vld});
    end
    n_tests++;
    if ({eng_char, eng_state} !== 19'd0) begin
      n_fail++; $display("FAIL reset_eng: char=%h state=%h required 0", eng_char, eng_state);
    end
    n_tests++;
    if ({match_flow, match_off} !== 20'd0) begin
      n_fail++; $display("FAIL reset_match: flow=%0d off=%0d required 0", match_flow, match_off);
    end
    n_tests++;
    if ({stat_pkts, stat_matches, stat_errs} !== 96'd0) begin
      n_fail++; $display("FAIL reset_stats: %0d %0d %0d required 0", stat_pkts, stat_matches, stat_errs);
    end
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    model_clear_all();
  endtask

  // One-byte SOP+EOP packet: trace per-cycle control outputs from the cycle SOP is seen.
  task automatic test_latency();
    logic [7:0] busy_v, rdy_v, svld_v, cvld_v;
    logic [7:0] char_at4;
    bit         pending;
    do_reset();
    busy_v = '0; rdy_v = '0; svld_v = '0; cvld_v = '0; char_at4 = '0;
    pkt_vld = 1'b1; pkt_sop = 1'b1; pkt_eop = 1'b1; pkt_flow = 4'd9; pkt_byte = "y";
    pending = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      busy_v[c] = busy; rdy_v[c] = pkt_rdy; svld_v[c] = eng_state_vld; cvld_v[c] = eng_char_vld;
      if (c == 4) char_at4 = eng_char;
      @(posedge clk); #1;
      if (pending && rdy_v[c]) begin
        idle_inputs(); pending = 1'b0; model_byte(9, "y", 0); m_pkts++;
      end
    end
    n_tests++;
    if (busy_v !== 8'b0011_1110) begin n_fail++; $display("FAIL lat_busy: trace=%b required 00111110", busy_v); end
    n_tests++;
    if (svld_v !== 8'b0000_0100) begin n_fail++; $display("FAIL lat_state_vld: trace=%b required 00000100", svld_v); end
    n_tests++;
    if (rdy_v !== 8'b0000_1000) begin n_fail++; $display("FAIL lat_rdy: trace=%b required 00001000", rdy_v); end
    n_tests++;
    if (cvld_v !== 8'b0001_0000) begin n_fail++; $display("FAIL lat_char_vld: trace=%b required 00010000", cvld_v); end
    n_tests++;
    if (char_at4 !== 8'h79) begin n_fail++; $display("FAIL lat_char: eng_char=%h required 79", char_at4); end
  endtask

  task automatic test_single_pkt();
    do_reset();
    send_pkt(3, str2q("yep yep"), 1'b1);
    settle();
    n_tests++;
    if (got_q.size() != 1) begin
      n_fail++; $display("FAIL single_count: matches=%0d required 1", got_q.size());
    end else begin
      n_tests++;
      if (got_q[0] !== mev_t'{4'd3, 16'd6}) begin
        n_fail++; $display("FAIL single_event: flow=%0d off=%0d required flow=3 off=6", got_q[0].flow, got_q[0].off);
      end
    end
    n_tests++;
    if (stat_matches !== (STATS_ON ? 32'd1 : 32'd0)) begin
      n_fail++; $display("FAIL single_stat_matches: %0d required %0d", stat_matches, STATS_ON ? 1 : 0);
    end
    n_tests++;
    if (stat_pkts !== (STATS_ON ? 32'd1 : 32'd0)) begin
      n_fail++; $display("FAIL single_stat_pkts: %0d required %0d", stat_pkts, STATS_ON ? 1 : 0);
    end
  endtask

  task automatic test_split_pkt();
    do_reset();
    send_pkt(5, str2q("yep "), 1'b1);
    send_pkt(5, str2q("yep"), 1'b1);
    settle();
    n_tests++;
    if (last_restore !== 11'd4) begin
      n_fail++; $display("FAIL split_restore: eng_state=%0d required 4", last_restore);
    end
    n_tests++;
    if (got_q.size() != 1 || got_q[0] !== mev_t'{4'd5, 16'd2}) begin
      n_fail++; $display("FAIL split_event: count=%0d first=%h required 1 event flow=5 off=2",
                         got_q.size(), (got_q.size() > 0) ? got_q[0] : mev_t'(0));
    end
  endtask

  task automatic test_interleave();
    do_reset();
    send_pkt(5, str2q("yep "), 1'b1);
    send_pkt(6, str2q("yep"), 1'b1);
    send_pkt(5, str2q("yep"), 1'b1);
    settle();
    n_tests++;
    if (got_q.size() != 1 || got_q[0] !== mev_t'{4'd5, 16'd2}) begin
      n_fail++; $display("FAIL interleave_event: count=%0d first=%h required 1 event flow=5 off=2",
                         got_q.size(), (got_q.size() > 0) ? got_q[0] : mev_t'(0));
    end
  endtask

  task automatic test_ctx_clr();
    do_reset();
    send_pkt(5, str2q("yep "), 1'b1);
    wait_idle();
    pulse_clr(5);
    send_pkt(5, str2q("yep"), 1'b1);
    settle();
    n_tests++;
    if (last_restore !== 11'd0) begin
      n_fail++; $display("FAIL clr_restore: eng_state=%0d required 0", last_restore);
    end
    n_tests++;
    if (got_q.size() != 0) begin
      n_fail++; $display("FAIL clr_nomatch: matches=%0d required 0", got_q.size());
    end
  endtask

  task automatic test_clr_races();
    // Clear coinciding with SAVE of the same flow.
    do_reset();
    send_pkt(5, str2q("yep "), 1'b1);
    @(posedge clk); #1;
    pulse_clr(5);
    send_pkt(5, str2q("yep"), 1'b1);
    settle();
    n_tests++;
    if (last_restore !== 11'd0 || got_q.size() != 0) begin
      n_fail++; $display("FAIL clr_at_save: restore=%0d matches=%0d required 0 and 0", last_restore, got_q.size());
    end
    // Clear coinciding with LOAD of the same flow.
    do_reset();
    send_pkt(5, str2q("yep "), 1'b1);
    wait_idle();
    pkt_vld = 1'b1; pkt_sop = 1'b1; pkt_eop = 1'b0; pkt_flow = 4'd5; pkt_byte = "y";
    @(posedge clk); #1;
    pulse_clr(5);
    send_pkt(5, str2q("yep"), 1'b1);
    settle();
    n_tests++;
    if (last_restore !== 11'd0 || got_q.size() != 0) begin
      n_fail++; $display("FAIL clr_at_load: restore=%0d matches=%0d required 0 and 0", last_restore, got_q.size());
    end
  endtask

  task automatic test_orphan_abort();
    int chars_before;
    do_reset();
    chars_before = n_char_vld;
    send_orphans(str2q("ab"));
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (n_char_vld != chars_before) begin
      n_fail++; $display("FAIL orphan_char_vld: eng_char_vld cycles=%0d required 0", n_char_vld - chars_before);
    end
    n_tests++;
    if (stat_errs !== (STATS_ON ? 32'd2 : 32'd0)) begin
      n_fail++; $display("FAIL orphan_stat_errs: %0d required %0d", stat_errs, STATS_ON ? 2 : 0);
    end
    send_pkt(7, str2q("yep"), 1'b0);
    send_pkt(7, str2q(" yep"), 1'b1);
    settle();
    n_tests++;
    if (got_q.size() != 1 || got_q[0] !== mev_t'{4'd7, 16'd3}) begin
      n_fail++; $display("FAIL abort_event: count=%0d first=%h required 1 event flow=7 off=3",
                         got_q.size(), (got_q.size() > 0) ? got_q[0] : mev_t'(0));
    end
    n_tests++;
    if (stat_errs !== (STATS_ON ? 32'd3 : 32'd0) || stat_pkts !== (STATS_ON ? 32'd2 : 32'd0)) begin
      n_fail++; $display("FAIL abort_stats: errs=%0d pkts=%0d required %0d %0d",
                         stat_errs, stat_pkts, STATS_ON ? 3 : 0, STATS_ON ? 2 : 0);
    end
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    send_pkt(2, str2q("yep "), 1'b1);
    wait_idle();
    send_pkt(2, str2q("ye"), 1'b0);
    rst = 1'b1;
    #1;
    n_tests++;
    if ({busy, pkt_rdy, eng_char_vld, eng_state_vld, match_vld} !== 5'b0 || eng_char !== 8'h00) begin
      n_fail++; $display("FAIL midreset_outputs: ctrl=%b char=%h required 00000 and 00",
                         {busy, pkt_rdy, eng_char_vld, eng_state_vld, match_vld}, eng_char);
    end
    @(posedge clk); #1 rst = 1'b0;
    model_clear_all();
    send_pkt(2, str2q("yep"), 1'b1);
    settle();
    n_tests++;
    if (last_restore !== 11'd0 || got_q.size() != 0) begin
      n_fail++; $display("FAIL midreset_restore: restore=%0d matches=%0d required 0 and 0", last_restore, got_q.size());
    end
  endtask

  task automatic test_random();
    string alpha, cyc;
    bit    prev_eop, eop;
    int    f, len, ph, n;
    bq_t   q;
    alpha = "yepx ";
    cyc   = "yep ";
    do_reset();
    prev_eop = 1'b1;
    for (int p = 0; p < 60; p++) begin
      if (prev_eop && $urandom_range(0, 9) == 0) begin
        wait_idle();
        pulse_clr($urandom_range(0, 3));
      end
      if (prev_eop && $urandom_range(0, 9) == 0) begin
        q.delete();
        for (int i = 0; i < $urandom_range(1, 2); i++) q.push_back(alpha[$urandom_range(0, 4)]);
        send_orphans(q);
      end
      f   = $urandom_range(0, 3);
      len = $urandom_range(1, 9);
      ph  = $urandom_range(0, 3);
      q.delete();
      for (int i = 0; i < len; i++) begin
        if (ph[0]) q.push_back(cyc[(ph + i) % 4]);
        else       q.push_back(alpha[$urandom_range(0, 4)]);
      end
      eop = (p == 59) || ($urandom_range(0, 6) != 0);
      send_pkt(f, q, eop);
      prev_eop = eop;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    settle();
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_count: matches=%0d required %0d", got_q.size(), exp_q.size());
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rand_event[%0d]: flow=%0d off=%0d required flow=%0d off=%0d",
                           i, got_q[i].flow, got_q[i].off, exp_q[i].flow, exp_q[i].off);
      end
    end
    n_tests++;
    if (n_overlap != 0) begin
      n_fail++; $display("FAIL vld_overlap: cycles with both valids=%0d required 0", n_overlap);
    end
    n_tests++;
    if (stat_pkts !== (STATS_ON ? 32'(m_pkts) : 32'd0) ||
        stat_matches !== (STATS_ON ? 32'(m_matches) : 32'd0) ||
        stat_errs !== (STATS_ON ? 32'(m_errs) : 32'd0)) begin
      n_fail++; $display("FAIL rand_stats: pkts=%0d matches=%0d errs=%0d required %0d %0d %0d",
                         stat_pkts, stat_matches, stat_errs,
                         STATS_ON ? m_pkts : 0, STATS_ON ? m_matches : 0, STATS_ON ? m_errs : 0);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_single_pkt();
    test_split_pkt();
    test_interleave();
    test_ctx_clr();
    test_clr_races();
    test_orphan_abort();
    test_reset_mid_stream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
